// File: rtl/scroll_pkg.sv
// scroll_pkg
// Shared definitions for the scrolling message display:
//   - state_t   : controller FSM states
//   - CODE_W    : width of one character code
//   - PTR_W     : width of the message window pointer
//   - MSG_ROM   : 16 x 4-bit message contents (identity 0x0..0xF by default)
//   - rom_at()  : window lookup with modulo-16 index wrap
package scroll_pkg;

    localparam int CODE_W    = 4;
    localparam int PTR_W     = 4;
    localparam int ROM_DEPTH = 16;

    typedef enum logic [1:0] {
        S_MANUAL = 2'd0,
        S_AUTO   = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    // Element 0 sits in the least significant nibble.
    localparam logic [ROM_DEPTH-1:0][CODE_W-1:0] MSG_ROM = {
        4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8,
        4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0
    };

    // The index is carried in PTR_W bits, so base+offset wraps modulo 16.
    function automatic logic [CODE_W-1:0] rom_at(input logic [PTR_W-1:0] base,
                                                 input logic [PTR_W-1:0] offset);
        logic [PTR_W-1:0] idx;
        idx = base + offset;
        return MSG_ROM[idx];
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
// Two-flop synchronizer followed by a stability counter. The debounced level
// only flips after the synchronized input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk              : system clock
//   reset            : synchronous, active-low reset
//   BTN2             : raw asynchronous, bouncing button
//   stabilizedButton : debounced button level (registered)
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic BTN2,
    output logic stabilizedButton
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] count_reg;
    logic             stable_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            count_reg  <= '0;
            stable_reg <= 1'b0;
        end else begin
            sync1_reg <= BTN2;
            sync2_reg <= sync1_reg;
            if (sync2_reg != stable_reg) begin
                // The edge that would bring the count to DEBOUNCE_CYCLES
                // flips the level instead and restarts the count.
                if (count_reg == CNT_LAST) begin
                    stable_reg <= ~stable_reg;
                    count_reg  <= '0;
                end else begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end else begin
                count_reg <= '0;
            end
        end
    end

    assign stabilizedButton = stable_reg;

endmodule

// File: rtl/scroll_controller.sv
// scroll_controller
// Scrolls a 16-entry message across a four-digit display, one position per
// button press (manual) or per AUTO_PERIOD cycles (auto). In auto mode a
// press toggles between running and holding.
// Ports:
//   clk              : system clock
//   reset            : synchronous, active-low reset
//   BTN2             : raw step/pause button
//   mode             : 0 = manual step, 1 = auto scroll
//   digit3..digit0   : character codes, digit3 leftmost (registered)
//   msg_ptr          : window start index (registered)
//   step_pulse       : one-cycle pulse on each advance (registered)
//   stabilizedButton : debounced BTN2 level (registered)
module scroll_controller
    import scroll_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        BTN2,
    input  logic        mode,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic [3:0]  msg_ptr,
    output logic        step_pulse,
    output logic        stabilizedButton
);

    localparam int PRE_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_PERIOD - 1);

    logic              stable;
    logic              stable_d_reg;
    logic              press;
    state_t            state_reg;
    state_t            state_next;
    logic [PRE_W-1:0]  presc_reg;
    logic [PRE_W-1:0]  presc_next;
    logic [PTR_W-1:0]  ptr_reg;
    logic [PTR_W-1:0]  ptr_next;
    logic              advance;
    logic              step_reg;
    logic [CODE_W-1:0] digit_reg  [4];
    logic [CODE_W-1:0] digit_next [4];

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk              (clk),
        .reset            (reset),
        .BTN2             (BTN2),
        .stabilizedButton (stable)
    );

    // Rising edge of the debounced level only; releases are ignored.
    assign press = stable & ~stable_d_reg;

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        advance    = 1'b0;
        case (state_reg)
            S_MANUAL: begin
                presc_next = '0;
                advance    = press;
                if (mode) begin
                    state_next = S_AUTO;
                end
            end
            S_AUTO: begin
                if (!mode) begin
                    state_next = S_MANUAL;
                    presc_next = '0;
                end else if (press) begin
                    // Press beats a coincident terminal count: the prescaler
                    // stays where it is and nothing advances.
                    state_next = S_HOLD;
                end else if (presc_reg == PRE_LAST) begin
                    presc_next = '0;
                    advance    = 1'b1;
                end else begin
                    presc_next = presc_reg + PRE_W'(1);
                end
            end
            S_HOLD: begin
                if (!mode) begin
                    state_next = S_MANUAL;
                    presc_next = '0;
                end else if (press) begin
                    state_next = S_AUTO;
                end
            end
            default: begin
                state_next = S_MANUAL;
                presc_next = '0;
            end
        endcase
        ptr_next = advance ? (ptr_reg + PTR_W'(1)) : ptr_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= S_MANUAL;
            presc_reg    <= '0;
            ptr_reg      <= '0;
            step_reg     <= 1'b0;
            stable_d_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            presc_reg    <= presc_next;
            ptr_reg      <= ptr_next;
            step_reg     <= advance;
            stable_d_reg <= stable;
        end
    end

    // Digits are looked up from the next pointer so they change on the same
    // edge as msg_ptr. Digit gi shows window position 3-gi.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign digit_next[gi] = rom_at(ptr_next, PTR_W'(3 - gi));

            always_ff @(posedge clk) begin
                if (!reset) begin
                    digit_reg[gi] <= rom_at('0, PTR_W'(3 - gi));
                end else begin
                    digit_reg[gi] <= digit_next[gi];
                end
            end
        end
    endgenerate

    assign digit3           = digit_reg[3];
    assign digit2           = digit_reg[2];
    assign digit1           = digit_reg[1];
    assign digit0           = digit_reg[0];
    assign msg_ptr          = ptr_reg;
    assign step_pulse       = step_reg;
    assign stabilizedButton = stable;

endmodule
